// File: rtl/demux32_1to2_buf_if.sv
// Handshake bundle for the 1-to-2 buffered demux: one upstream input, two buffered output ports.
interface demux32_1to2_buf_if;
  logic        in_valid;
  logic        in_ready;
  logic        Ctrl;
  logic [31:0] S;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] A;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] B;
  logic        busy;

  modport master (
    output in_valid, Ctrl, S, a_ready, b_ready,
    input  in_ready, a_valid, A, b_valid, B, busy
  );

  modport slave (
    input  in_valid, Ctrl, S, a_ready, b_ready,
    output in_ready, a_valid, A, b_valid, B, busy
  );
endinterface

// File: rtl/demux32_1to2_buf.sv
// Routes 32-bit words to port A or B by Ctrl; each port has its own 2-entry FIFO.
module demux32_1to2_buf (
  input  logic              clk,
  input  logic              rst,
  demux32_1to2_buf_if.slave bus
);

  // Index 0 is port A, index 1 is port B.
  logic [31:0] mem [2][2];
  logic [1:0]  cnt [2];
  logic        rd_ptr [2];
  logic        wr_ptr [2];
  logic        push [2];
  logic        pop [2];
  logic        ready [2];
  logic        fire;

  assign ready[0] = bus.a_ready;
  assign ready[1] = bus.b_ready;

  // Full means full: a pop in the same cycle does not open a slot.
  assign bus.in_ready = bus.Ctrl ? (cnt[1] < 2'd2) : (cnt[0] < 2'd2);
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    push[0] = fire && !bus.Ctrl;
    push[1] = fire &&  bus.Ctrl;
    pop[0]  = (cnt[0] != 2'd0) && ready[0];
    pop[1]  = (cnt[1] != 2'd0) && ready[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        cnt[p]    <= 2'd0;
        rd_ptr[p] <= 1'b0;
        wr_ptr[p] <= 1'b0;
        for (int e = 0; e < 2; e++) mem[p][e] <= 32'h0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          mem[p][wr_ptr[p]] <= bus.S;
          wr_ptr[p]         <= ~wr_ptr[p];
        end
        if (pop[p]) rd_ptr[p] <= ~rd_ptr[p];
        case ({push[p], pop[p]})
          2'b10:   cnt[p] <= cnt[p] + 2'd1;
          2'b01:   cnt[p] <= cnt[p] - 2'd1;
          default: cnt[p] <= cnt[p];
        endcase
      end
    end
  end

  assign bus.a_valid = (cnt[0] != 2'd0);
  assign bus.b_valid = (cnt[1] != 2'd0);
  assign bus.A       = mem[0][rd_ptr[0]];
  assign bus.B       = mem[1][rd_ptr[1]];
  assign bus.busy    = bus.a_valid || bus.b_valid;

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Directed bench for demux32_1to2_buf: routing, fill/full, ordering, no-bypass, push+pop, reset.
module tb_demux32_1to2_buf;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux32_1to2_buf_if bus ();

  demux32_1to2_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.Ctrl     = 1'b0;
    bus.S        = 32'h0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_a_valid", {31'h0, bus.a_valid}, 32'h0);
    chk("rst_b_valid", {31'h0, bus.b_valid}, 32'h0);
    chk("rst_A", bus.A, 32'h0);
    chk("rst_B", bus.B, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    bus.Ctrl = 1'b0; #1;
    chk("rst_in_ready_c0", {31'h0, bus.in_ready}, 32'h1);
    bus.Ctrl = 1'b1; #1;
    chk("rst_in_ready_c1", {31'h0, bus.in_ready}, 32'h1);

    // Route one word to A
    bus.Ctrl = 1'b0; bus.S = 32'hDEADBEEF; bus.in_valid = 1'b1;
    tick();
    idle();
    chk("route_a_valid", {31'h0, bus.a_valid}, 32'h1);
    chk("route_A", bus.A, 32'hDEADBEEF);
    chk("route_b_valid", {31'h0, bus.b_valid}, 32'h0);
    chk("route_busy", {31'h0, bus.busy}, 32'h1);
    bus.a_ready = 1'b1;
    tick();
    idle();
    chk("route_pop_a_valid", {31'h0, bus.a_valid}, 32'h0);
    chk("route_pop_busy", {31'h0, bus.busy}, 32'h0);

    // Ready with empty FIFO changes nothing; Ctrl without in_valid does nothing
    bus.b_ready = 1'b1; bus.Ctrl = 1'b1; bus.S = 32'h5A5A5A5A;
    tick();
    idle();
    chk("empty_ready_b_valid", {31'h0, bus.b_valid}, 32'h0);
    chk("empty_ready_busy", {31'h0, bus.busy}, 32'h0);

    // Fill A, then B still accepts
    bus.Ctrl = 1'b0; bus.in_valid = 1'b1; bus.S = 32'h1;
    tick();
    bus.S = 32'h2;
    tick();
    idle();
    chk("fill_A_head", bus.A, 32'h1);
    bus.Ctrl = 1'b0; #1;
    chk("full_in_ready_c0", {31'h0, bus.in_ready}, 32'h0);
    bus.Ctrl = 1'b1; #1;
    chk("full_in_ready_c1", {31'h0, bus.in_ready}, 32'h1);
    // A word offered to the full port must not be taken
    bus.Ctrl = 1'b0; bus.S = 32'h99; bus.in_valid = 1'b1;
    tick();
    bus.Ctrl = 1'b1; bus.S = 32'h3;
    tick();
    idle();
    chk("indep_b_valid", {31'h0, bus.b_valid}, 32'h1);
    chk("indep_B", bus.B, 32'h3);
    chk("indep_A_head", bus.A, 32'h1);

    // Full, no bypass: pop A and offer a push in the same cycle
    bus.a_ready = 1'b1; bus.in_valid = 1'b1; bus.Ctrl = 1'b0; bus.S = 32'h55;
    #1;
    chk("nobypass_in_ready", {31'h0, bus.in_ready}, 32'h0);
    tick();
    idle();
    chk("nobypass_A_next", bus.A, 32'h2);
    chk("nobypass_a_valid", {31'h0, bus.a_valid}, 32'h1);
    bus.Ctrl = 1'b0; #1;
    chk("nobypass_in_ready_after", {31'h0, bus.in_ready}, 32'h1);

    // Simultaneous push+pop with count 1
    bus.in_valid = 1'b1; bus.Ctrl = 1'b0; bus.S = 32'hAA; bus.a_ready = 1'b1;
    tick();
    idle();
    chk("simul_A", bus.A, 32'hAA);
    chk("simul_a_valid", {31'h0, bus.a_valid}, 32'h1);
    bus.a_ready = 1'b1;
    tick();
    idle();
    chk("simul_count_one", {31'h0, bus.a_valid}, 32'h0);

    // Drain B
    bus.b_ready = 1'b1;
    tick();
    idle();
    chk("drain_b_valid", {31'h0, bus.b_valid}, 32'h0);

    // Order and pointer wrap on B with ready held high
    bus.b_ready = 1'b1; bus.Ctrl = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.S = 32'h10 + i;
      tick();
      chk("order_b_valid", {31'h0, bus.b_valid}, 32'h1);
      chk("order_B", bus.B, 32'h10 + i);
    end
    bus.in_valid = 1'b0;
    tick();
    idle();
    chk("order_drained", {31'h0, bus.b_valid}, 32'h0);

    // Reset mid-operation with a concurrent input word
    bus.in_valid = 1'b1; bus.Ctrl = 1'b0; bus.S = 32'h21;
    tick();
    bus.Ctrl = 1'b1; bus.S = 32'h31;
    tick();
    idle();
    chk("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1; bus.in_valid = 1'b1; bus.Ctrl = 1'b0; bus.S = 32'h77;
    tick();
    rst = 1'b0;
    idle();
    chk("midrst_a_valid", {31'h0, bus.a_valid}, 32'h0);
    chk("midrst_b_valid", {31'h0, bus.b_valid}, 32'h0);
    chk("midrst_A", bus.A, 32'h0);
    chk("midrst_B", bus.B, 32'h0);
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/demux32_1to2_buf.md
DEMUX32_1TO2_BUF -- requirements
Module: demux32_1to2_buf

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream word S is presented.
REQ-005 in_ready  output  1  block accepts S this cycle.
REQ-006 Ctrl  input  1  route select for S: 0 to port A, 1 to port B.
REQ-007 S  input  32  input data word.
REQ-008 a_valid  output  1  port A head word available.
REQ-009 a_ready  input  1  port A consumer takes head word.
REQ-010 A  output  32  port A head word.
REQ-011 b_valid  output  1  port B head word available.
REQ-012 b_ready  input  1  port B consumer takes head word.
REQ-013 B  output  32  port B head word.
REQ-014 busy  output  1  at least one word is held in either port buffer.

Function
REQ-015 Each port SHALL own a 2-entry FIFO with registered storage, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count (0..2).
REQ-016 in_ready SHALL equal (Ctrl==0 ? a_count<2 : b_count<2), combinational on Ctrl and the counts only.
REQ-017 An input transfer SHALL occur on a rising edge when in_valid && in_ready, writing S into the FIFO selected by Ctrl.
REQ-018 Ctrl SHALL be meaningful only in a cycle with in_valid=1; it has no effect otherwise.
REQ-019 a_valid SHALL equal (a_count!=0) and b_valid SHALL equal (b_count!=0), driven from registers only.
REQ-020 A and B SHALL always show the storage entry at their read pointer; the value is don't-care to consumers while the valid is 0.
REQ-021 A port pop SHALL occur on a rising edge when that port's valid && ready; the read pointer then advances modulo 2.
REQ-022 Latency: a word accepted at edge N SHALL be visible with valid=1 in the cycle after edge N; there is no combinational path from S to A or B.
REQ-023 Push and pop on the same port in the same edge with count=1 SHALL leave count=1 and present the new word next.
REQ-024 When count=2, in_ready for that port SHALL be 0 even if that port pops in the same cycle (no full bypass).
REQ-025 A pop with count=0 SHALL be impossible because valid is 0; an asserted ready with valid=0 SHALL change nothing.
REQ-026 Word order SHALL be preserved per port; there is no ordering relation between ports.
REQ-027 Ports A and B SHALL operate independently: a stalled port SHALL not block input routed to the other port.
REQ-028 No word SHALL be dropped or duplicated; a word is either accepted, or in_ready was 0.
REQ-029 busy SHALL equal a_valid || b_valid.

Reset
REQ-030 A rising edge with rst=1 SHALL clear both counts and all pointers to 0 and all storage to 32'h0, and discard held words.
REQ-031 While rst=1, a transfer or pop in the same edge SHALL be ignored; reset has priority.
REQ-032 After reset: a_valid=0, b_valid=0, A=0, B=0, busy=0, and in_ready=1 for either Ctrl value.

Verification
REQ-033 Route: Ctrl=0, S=32'hDEADBEEF, in_valid=1 for one cycle, a_ready=0 -> next cycle a_valid=1, A=DEADBEEF, b_valid=0, busy=1.
REQ-034 Fill/full: with a_ready=0, push 32'h1 then 32'h2 to A -> a_count=2, and in_ready=0 with Ctrl=0 but 1 with Ctrl=1; push 32'h3 to B -> b_valid=1, B=3.
REQ-035 Order/wrap: push 32'h10, 32'h11, 32'h12, 32'h13 to B with b_ready=1 throughout -> B shows 10, 11, 12, 13 in order, no loss; the pointers wrap twice.
REQ-036 Full, no bypass: with A full, set a_ready=1 and in_valid=1, Ctrl=0 in the same cycle -> one pop, no push that cycle; in the next cycle in_ready=1.
REQ-037 Simultaneous: a_count=1, then push 32'hAA to A and pop A in the same edge -> a_count=1, A=AA.
REQ-038 Reset mid-operation: both FIFOs hold words, rst=1 for one edge together with in_valid=1 -> all valids 0, A=B=0, busy=0, and the input word is not stored.
